// File: rtl/line_mem_responder_pkg.sv
// rtl/line_mem_responder_pkg.sv - shared line-protocol definitions for the memory responder
//
// Purpose: line and address widths, FSM state encodings and the word lane
// order of a line, shared by the responder top and its storage array.
// Lane order: word0 = line[31:0], word1 = [63:32], word2 = [95:64], word3 = [127:96].
// Ports: none (package).
package line_mem_responder_pkg;

  localparam int LINE_W         = 128;
  localparam int MADDR_W        = 28;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = LINE_W / WORD_W;
  localparam int CNT_W          = 4;
  localparam int STAT_W         = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Saturating increment for the completion counters; never wraps to zero.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/line_mem_responder_array.sv
// rtl/line_mem_responder_array.sv - line storage with one sync read port and two write ports
//
// Purpose: 2**DEPTH_LOG2 x LINE_W line storage. The protocol write port has
// priority over the backdoor init port when both hit the same index on one edge.
// The read port is synchronous; a read sees the contents from before any write
// landing on the same edge.
// Ports:
//   clk, rst_n                clock; async active-low reset (read register only)
//   rd_en, rd_idx, rd_data    sync read: rd_data <= mem[rd_idx] when rd_en
//   pwr_en, pwr_idx, pwr_data protocol write port
//   init_en, init_idx, init_data backdoor write port
module line_mem_array
  import line_mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_idx,
  output logic [LINE_W-1:0]     rd_data,
  input  logic                  pwr_en,
  input  logic [DEPTH_LOG2-1:0] pwr_idx,
  input  logic [LINE_W-1:0]     pwr_data,
  input  logic                  init_en,
  input  logic [DEPTH_LOG2-1:0] init_idx,
  input  logic [LINE_W-1:0]     init_data
);

  logic [LINE_W-1:0] mem [2**DEPTH_LOG2];

  // Contents are deliberately not reset. The protocol write is issued last so
  // it overrides an init write to the same index on the same edge.
  always_ff @(posedge clk) begin
    if (init_en) mem[init_idx] <= init_data;
    if (pwr_en)  mem[pwr_idx]  <= pwr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/line_mem_responder.sv
// rtl/line_mem_responder.sv - memory-side responder for the cache line protocol
//
// Purpose: accepts one line read/write at a time, answers after LATENCY clocks
// with a one-cycle registered mem_ready pulse, and counts completions.
// Ports:
//   clk, proc_reset_n            clock; async active-low reset
//   mem_read, mem_write          level requests, held until mem_ready (write wins)
//   mem_addr, mem_wdata          line address / write line (latched on acceptance)
//   mem_rdata, mem_ready         registered read line and completion pulse
//   init_we, init_addr, init_data backdoor line preload
//   rd_count, wr_count           saturating completion counters
module line_mem_responder
  import line_mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  proc_reset_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [MADDR_W-1:0]    mem_addr,
  input  logic [LINE_W-1:0]     mem_wdata,
  output logic [LINE_W-1:0]     mem_rdata,
  output logic                  mem_ready,
  input  logic                  init_we,
  input  logic [DEPTH_LOG2-1:0] init_addr,
  input  logic [LINE_W-1:0]     init_data,
  output logic [STAT_W-1:0]     rd_count,
  output logic [STAT_W-1:0]     wr_count
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t                state, state_next;
  logic [CNT_W-1:0]      cnt;
  logic [DEPTH_LOG2-1:0] lat_idx;
  logic [LINE_W-1:0]     lat_wdata;
  logic                  lat_write;
  logic                  req;
  logic                  resp_rd;
  logic                  resp_wr;
  logic                  unused_addr_hi;

  // Lines alias: address bits above the array index are simply dropped.
  assign unused_addr_hi = ^mem_addr[MADDR_W-1:DEPTH_LOG2];

  assign req     = mem_read | mem_write;
  // All completion effects (ready pulse, read data, write commit, counters)
  // land on the edge leaving RESP, which is edge N+LATENCY after acceptance.
  assign resp_rd = (state == ST_RESP) && !lat_write;
  assign resp_wr = (state == ST_RESP) &&  lat_write;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (req) state_next = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      // cnt==0 covers a counter that was loaded with zero on entry.
      ST_WAIT: if (cnt <= CNT_W'(1)) state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_write <= 1'b0;
      mem_ready <= 1'b0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      state     <= state_next;
      mem_ready <= (state == ST_RESP);
      case (state)
        ST_IDLE: begin
          if (req) begin
            lat_idx   <= mem_addr[DEPTH_LOG2-1:0];
            lat_wdata <= mem_wdata;
            lat_write <= mem_write;
            cnt       <= CNT_LOAD;
          end
        end
        ST_WAIT: if (cnt != '0) cnt <= cnt - 1'b1;
        ST_RESP: begin
          if (resp_rd) rd_count <= sat_inc(rd_count);
          if (resp_wr) wr_count <= sat_inc(wr_count);
        end
        default: ;
      endcase
    end
  end

  line_mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk      (clk),
    .rst_n    (proc_reset_n),
    .rd_en    (resp_rd),
    .rd_idx   (lat_idx),
    .rd_data  (mem_rdata),
    .pwr_en   (resp_wr),
    .pwr_idx  (lat_idx),
    .pwr_data (lat_wdata),
    .init_en  (init_we),
    .init_idx (init_addr),
    .init_data(init_data)
  );

endmodule

// File: tb/tb_line_mem_responder.sv
// tb/tb_line_mem_responder.sv - directed self-checking bench for line_mem_responder
module tb_line_mem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // LATENCY=4 instance
  logic         r4 = 0, w4 = 0, iwe4 = 0;
  logic [27:0]  a4 = '0;
  logic [127:0] d4 = '0, id4 = '0;
  logic [7:0]   ia4 = '0;
  logic [127:0] rdata4;
  logic         ready4;
  logic [15:0]  rc4, wc4;

  // LATENCY=1 instance
  logic         r1 = 0, w1 = 0, iwe1 = 0;
  logic [27:0]  a1 = '0;
  logic [127:0] d1 = '0, id1 = '0;
  logic [7:0]   ia1 = '0;
  logic [127:0] rdata1;
  logic         ready1;
  logic [15:0]  rc1, wc1;

  int checks = 0;
  int failures = 0;
  int lat;
  logic seen;

  localparam logic [127:0] L5 = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
  localparam logic [127:0] DD = 128'hDEADBEEF_01234567_89ABCDEF_F00DCAFE;
  localparam logic [127:0] EE = 128'hEEEE0001_EEEE0002_EEEE0003_EEEE0004;
  localparam logic [127:0] FF = 128'hF3F3F3F3_0000FFFF_12121212_A5A5A5A5;
  localparam logic [127:0] GG = 128'h6666_6666_7777_7777_8888_8888_9999_9999;
  localparam logic [127:0] HH = 128'h0707_0707_1717_1717_2727_2727_3737_3737;
  localparam logic [127:0] JJ = 128'h1010_1010_A0A0_A0A0_B0B0_B0B0_C0C0_C0C0;
  localparam logic [127:0] PP = 128'hAAAA_0000_BBBB_1111_CCCC_2222_DDDD_3333;
  localparam logic [127:0] QQ = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
  localparam logic [127:0] RR = 128'h1313_1313_1313_1313_0000_0000_1313_1313;
  localparam logic [127:0] SS = 128'h9876_5432_1098_7654_3210_FEDC_BA98_7654;

  line_mem_responder #(.DEPTH_LOG2(8), .LATENCY(4)) dut4 (
    .clk(clk), .proc_reset_n(rst_n),
    .mem_read(r4), .mem_write(w4), .mem_addr(a4), .mem_wdata(d4),
    .mem_rdata(rdata4), .mem_ready(ready4),
    .init_we(iwe4), .init_addr(ia4), .init_data(id4),
    .rd_count(rc4), .wr_count(wc4)
  );

  line_mem_responder #(.DEPTH_LOG2(8), .LATENCY(1)) dut1 (
    .clk(clk), .proc_reset_n(rst_n),
    .mem_read(r1), .mem_write(w1), .mem_addr(a1), .mem_wdata(d1),
    .mem_rdata(rdata1), .mem_ready(ready1),
    .init_we(iwe1), .init_addr(ia1), .init_data(id1),
    .rd_count(rc1), .wr_count(wc1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic init4(input logic [7:0] idx, input logic [127:0] data);
    iwe4 = 1; ia4 = idx; id4 = data;
    step();
    iwe4 = 0;
  endtask

  task automatic init1(input logic [7:0] idx, input logic [127:0] data);
    iwe1 = 1; ia1 = idx; id1 = data;
    step();
    iwe1 = 0;
  endtask

  // Issue a request on dut4; returns clocks from acceptance edge to mem_ready
  // (-1 on timeout). hold>0 drops the request (and scrambles the address)
  // that many clocks after acceptance; hold=0 holds until mem_ready.
  task automatic txn4(input logic rd, input logic wr, input logic [27:0] addr,
                      input logic [127:0] data, input int hold, output int l);
    r4 = rd; w4 = wr; a4 = addr; d4 = data;
    step();
    l = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (hold != 0 && k == hold) begin
        r4 = 0; w4 = 0; a4 = 28'h5; d4 = '0;
      end
      if (ready4) begin
        l = k;
        r4 = 0; w4 = 0;
        break;
      end
    end
  endtask

  initial begin
    // reset state
    rst_n = 0;
    step();
    chk("rst_ready", 128'(ready4), 128'd0);
    chk("rst_rdata", rdata4, '0);
    chk("rst_rc", 128'(rc4), 128'd0);
    chk("rst_wc", 128'(wc4), 128'd0);
    rst_n = 1;
    step();

    // 1: preload line 5, read it back with LATENCY=4
    init4(8'd5, L5);
    txn4(1, 0, 28'd5, '0, 0, lat);
    chk("t1_lat", 128'(lat), 128'd4);
    chk("t1_rdata", rdata4, L5);
    chk("t1_rc", 128'(rc4), 128'd1);
    step();
    chk("t1_pulse_one_cycle", 128'(ready4), 128'd0);

    // 2: write line 9 then read it
    txn4(0, 1, 28'd9, DD, 0, lat);
    chk("t2_wr_lat", 128'(lat), 128'd4);
    chk("t2_wc", 128'(wc4), 128'd1);
    chk("t2_rdata_held", rdata4, L5);
    step();
    txn4(1, 0, 28'd9, '0, 0, lat);
    chk("t2_rdata", rdata4, DD);
    chk("t2_rc", 128'(rc4), 128'd2);
    step();

    // 3: read+write together at line 2 behaves as a write
    txn4(1, 1, 28'd2, EE, 0, lat);
    chk("t3_lat", 128'(lat), 128'd4);
    chk("t3_wc", 128'(wc4), 128'd2);
    chk("t3_rc", 128'(rc4), 128'd2);
    chk("t3_rdata_held", rdata4, DD);
    step();
    txn4(1, 0, 28'd2, '0, 0, lat);
    chk("t3_readback", rdata4, EE);
    step();

    // 4: request dropped after one WAIT cycle; address 256+3 aliases line 3
    init4(8'd3, FF);
    txn4(1, 0, 28'd259, '0, 1, lat);
    chk("t4_lat", 128'(lat), 128'd4);
    chk("t4_rdata", rdata4, FF);
    chk("t4_rc", 128'(rc4), 128'd4);
    step();
    chk("t4_no_repeat", 128'(ready4), 128'd0);

    // 5: reset in the middle of a write to line 7
    init4(8'd7, HH);
    w4 = 1; a4 = 28'd7; d4 = GG;
    step();
    step();
    rst_n = 0;
    #1;
    chk("t5_ready", 128'(ready4), 128'd0);
    chk("t5_rc", 128'(rc4), 128'd0);
    chk("t5_wc", 128'(wc4), 128'd0);
    chk("t5_rdata", rdata4, '0);
    w4 = 0;
    step();
    rst_n = 1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (ready4) seen = 1;
    end
    chk("t5_no_pulse", 128'(seen), 128'd0);
    txn4(1, 0, 28'd7, '0, 0, lat);
    chk("t5_lat", 128'(lat), 128'd4);
    chk("t5_line7_kept", rdata4, HH);
    chk("t5_wc_after", 128'(wc4), 128'd0);
    step();

    // 6: LATENCY=1, mem_read held across two transactions
    init1(8'd10, JJ);
    r1 = 1; a1 = 28'd10;
    step();
    step();
    chk("t6_pulse1", 128'(ready1), 128'd1);
    chk("t6_rdata", rdata1, JJ);
    step();
    chk("t6_gap", 128'(ready1), 128'd0);
    step();
    chk("t6_pulse2", 128'(ready1), 128'd1);
    r1 = 0;
    step();
    chk("t6_after", 128'(ready1), 128'd0);
    chk("t6_rc", 128'(rc1), 128'd2);

    // 6b: init and protocol write to line 12 on the same edge -> protocol wins
    w1 = 1; a1 = 28'd12; d1 = PP;
    step();
    w1 = 0;
    iwe1 = 1; ia1 = 8'd12; id1 = QQ;
    step();
    iwe1 = 0;
    chk("t6_wr_ready", 128'(ready1), 128'd1);
    chk("t6_wc", 128'(wc1), 128'd1);
    step();
    r1 = 1; a1 = 28'd12;
    step();
    r1 = 0;
    step();
    chk("t6_collision", rdata1, PP);
    step();

    // 6c: a read completing on the edge of an init to its line sees old data
    init1(8'd13, RR);
    r1 = 1; a1 = 28'd13;
    step();
    r1 = 0;
    iwe1 = 1; ia1 = 8'd13; id1 = SS;
    step();
    iwe1 = 0;
    chk("t6_pre_init", rdata1, RR);
    step();
    r1 = 1; a1 = 28'd13;
    step();
    r1 = 0;
    step();
    chk("t6_post_init", rdata1, SS);
    chk("t6_rc_final", 128'(rc1), 128'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
